// File: rtl/addr_loader.sv
// Serial address front end: receives a framed MSB-first address from the AVR,
// synchronises it into the clk domain, commits it to the SRAM address, and
// auto-increments on each access-done pulse.
module addr_loader #(
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              sdi,
  input  logic              sel_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              done,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(ADDR_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(ADDR_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] sel_n_sync_q, sel_n_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   sel_n_prev_q, sel_n_prev_d;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   addr_valid_q, addr_valid_d;
  logic                   done_q, done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;

  logic sclk_s, sdi_s, sel_n_s;
  logic sclk_rise, sel_fall, sel_rise;

  // Synchroniser chains and edge-detect history for the AVR inputs
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    sdi_sync_d   = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    sel_n_sync_d = {sel_n_sync_q[SYNC_STAGES-2:0], sel_n};
    sclk_prev_d  = sclk_sync_q[SYNC_STAGES-1];
    sel_n_prev_d = sel_n_sync_q[SYNC_STAGES-1];
  end

  // Synchronised levels and edges seen by the FSM
  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    sel_n_s   = sel_n_sync_q[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_prev_q;
    sel_fall  = ~sel_n_s & sel_n_prev_q;
    sel_rise  = sel_n_s & ~sel_n_prev_q;
  end

  // Next-state, shift path, address update and flags
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    done_d       = 1'b0;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        if (inc) addr_d = ADDR_W'(addr_q + 1'b1);
        if (sel_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        if (inc) addr_d = ADDR_W'(addr_q + 1'b1);
        if (sel_rise) begin
          if (cnt_q == CNT_FULL) begin
            state_d = COMMIT;
          end else begin
            // Short or over-long frame: drop it, keep the current address
            frame_err_d = 1'b1;
            shreg_d     = '0;
            state_d     = IDLE;
          end
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[ADDR_W-2:0], sdi_s};
          if (cnt_q != CNT_SAT) cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      COMMIT: begin
        // A coincident inc is dropped: the freshly loaded address wins
        addr_d       = shreg_q;
        addr_valid_d = 1'b1;
        done_d       = 1'b1;
        frame_err_d  = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q  <= '0;
      sdi_sync_q   <= '0;
      sel_n_sync_q <= '1;
      sclk_prev_q  <= 1'b0;
      sel_n_prev_q <= 1'b1;
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      sdi_sync_q   <= sdi_sync_d;
      sel_n_sync_q <= sel_n_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      sel_n_prev_q <= sel_n_prev_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      done_q       <= done_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign done       = done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_addr_loader.sv
// Directed testbench for addr_loader: framing, commit latency, increment,
// wrap, bad frames, inc/commit collision and asynchronous reset mid-frame.
module tb_addr_loader;

  localparam int unsigned ADDR_W      = 21;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned PH          = 5;  // clk periods per sclk phase

  logic              clk = 1'b0;
  logic              reset;
  logic              sclk;
  logic              sdi;
  logic              sel_n;
  logic              inc;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              done;
  logic              frame_err;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  addr_loader #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .sdi        (sdi),
    .sel_n      (sel_n),
    .inc        (inc),
    .addr       (addr),
    .addr_valid (addr_valid),
    .done       (done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    sel_n = 1'b0;
    repeat (PH) @(negedge clk);
  endtask

  // Send bits nbits-1..0 of val, MSB first
  task automatic send_bits(input logic [31:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = val[i];
      repeat (PH) @(negedge clk);
      sclk = 1'b1;
      repeat (PH) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (PH) @(negedge clk);
  endtask

  // Raise sel_n; checks nothing has changed one cycle before the commit edge,
  // optionally drives inc during the COMMIT cycle, returns just after the commit edge
  task automatic end_frame(input logic inc_commit, input logic [31:0] prev_addr);
    sel_n = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    check("done_early", 32'(done), 32'd0);
    check("addr_early", 32'(addr), prev_addr);
    inc = inc_commit;
    @(negedge clk);
    inc = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    inc = 1'b1;
    repeat (n) @(negedge clk);
    inc = 1'b0;
  endtask

  // Good frame: commit lands exactly SYNC_STAGES+2 clk after sel_n rise, done is one cycle
  task automatic good_frame(input logic [31:0] val, input logic [31:0] prev_addr);
    start_frame();
    send_bits(val, ADDR_W);
    end_frame(1'b0, prev_addr);
    check("commit_addr", 32'(addr), val);
    check("commit_done", 32'(done), 32'd1);
    check("commit_valid", 32'(addr_valid), 32'd1);
    check("commit_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  // Bad frame of nbits: flag set, address held, no done
  task automatic bad_frame(input logic [31:0] val, input int nbits, input logic [31:0] held);
    start_frame();
    send_bits(val, nbits);
    end_frame(1'b0, held);
    check("bad_err", 32'(frame_err), 32'd1);
    check("bad_addr", 32'(addr), held);
    check("bad_done", 32'(done), 32'd0);
    check("bad_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    sclk  = 1'b0;
    sdi   = 1'b0;
    sel_n = 1'b1;
    inc   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // inc before any commit counts from 0 but does not validate the address
    pulse_inc(1);
    check("pre_inc_addr", 32'(addr), 32'd1);
    check("pre_inc_valid", 32'(addr_valid), 32'd0);

    // First frame
    start_frame();
    check("busy_in_frame", 32'(busy), 32'd1);
    send_bits(32'h012345, ADDR_W);
    end_frame(1'b0, 32'd1);
    check("f1_addr", 32'(addr), 32'h012345);
    check("f1_done", 32'(done), 32'd1);
    check("f1_valid", 32'(addr_valid), 32'd1);
    check("f1_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    check("f1_done_pulse", 32'(done), 32'd0);
    check("f1_busy", 32'(busy), 32'd0);

    // Three access-done pulses
    pulse_inc(3);
    check("inc3_addr", 32'(addr), 32'h012348);
    check("inc3_done", 32'(done), 32'd0);

    // Wrap from all-ones
    good_frame(32'h1FFFFF, 32'h012348);
    pulse_inc(1);
    check("wrap_addr", 32'(addr), 32'h000000);
    check("wrap_valid", 32'(addr_valid), 32'd1);
    check("wrap_err", 32'(frame_err), 32'd0);
    check("wrap_done", 32'(done), 32'd0);

    // sel_n pulse with no sclk edges is a bad frame
    bad_frame(32'd0, 0, 32'd0);

    // Good commit clears the flag; then short and over-long frames
    good_frame(32'h0000AA, 32'd0);
    bad_frame(32'h012345, 20, 32'h0000AA);
    good_frame(32'h0000AA, 32'h0000AA);
    bad_frame(32'h3FFFFF, 22, 32'h0000AA);
    good_frame(32'h000055, 32'h0000AA);

    // inc in the COMMIT cycle is dropped
    start_frame();
    send_bits(32'h100000, ADDR_W);
    end_frame(1'b1, 32'h000055);
    check("collide_addr", 32'(addr), 32'h100000);
    check("collide_done", 32'(done), 32'd1);
    @(negedge clk);
    check("collide_addr_hold", 32'(addr), 32'h100000);

    // inc during SHIFT moves addr while the frame completes normally
    start_frame();
    send_bits(32'h000123 >> 11, 10);
    pulse_inc(4);
    check("shift_inc_addr", 32'(addr), 32'h100004);
    check("shift_inc_busy", 32'(busy), 32'd1);
    send_bits(32'h000123, 11);
    end_frame(1'b0, 32'h100004);
    check("shift_frame_addr", 32'(addr), 32'h000123);
    check("shift_frame_done", 32'(done), 32'd1);
    @(negedge clk);

    // Asynchronous reset in the middle of a frame
    start_frame();
    send_bits(32'h0ABCDE >> 11, 10);
    #3;
    reset = 1'b0;
    #1;
    check("arst_addr", 32'(addr), 32'd0);
    check("arst_valid", 32'(addr_valid), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_err", 32'(frame_err), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    sel_n = 1'b1;
    sclk  = 1'b0;
    sdi   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_idle_busy", 32'(busy), 32'd0);
    good_frame(32'h0ABCDE, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_loader.md
Name: addr_loader

Overview:
Serial address front end between the AVR and the SRAM bus.
- Receives a framed, MSB-first serial address from the AVR (sclk/sdi/sel_n) and synchronises it into the system clock domain.
- Commits the address to the sram_addr drivers.
- Auto-increments the address on each access-done pulse from bus_fsm, so block transfers need only one address frame.

Parameters:
ADDR_W, 21, address width; frame length in bits.
SYNC_STAGES, 2, flip-flop stages on each of sclk, sdi and sel_n; legal values 2 or 3.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset.
sclk  input  1  AVR serial clock; asynchronous to clk; sampled.
sdi  input  1  AVR serial data; MSB first; sampled on sclk rising edge.
sel_n  input  1  frame select, active-low; asynchronous.
inc  input  1  access-done pulse from bus_fsm; one clk wide per access.
addr  output  ADDR_W  current SRAM address.
addr_valid  output  1  high once any frame has committed; stays high until reset.
done  output  1  one-cycle pulse on each successful commit.
frame_err  output  1  sticky bad-frame flag.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync release) forces:
  - addr=0, addr_valid=0, done=0, frame_err=0.
  - State IDLE, shift register=0, bit count=0.
  - Synchronisers preset to sclk=0, sdi=0, sel_n=1.
- Synchronisers: SYNC_STAGES flops per input. Edge detectors run on the synchronised outputs.
- Input timing: sclk high and low phases must each be at least SYNC_STAGES+1 clk periods. Faster sclk is out of spec; the block may behave arbitrarily.
- Shift path:
  - Each synchronised sclk rising edge while synchronised sel_n=0 does shreg <= {shreg[ADDR_W-2:0], sdi_sync}.
  - Bit count increments, saturating at ADDR_W+1.
- FSM states:
  - IDLE: sel_n falling edge → SHIFT; clear bit count.
  - SHIFT: shift as above.
    - sel_n rising edge with count==ADDR_W → COMMIT.
    - sel_n rising edge with count!=ADDR_W (short or over-long frame) → frame_err=1, shreg discarded, addr unchanged → IDLE.
  - COMMIT (one cycle): addr<=shreg, addr_valid<=1, done=1, frame_err<=0 → IDLE.
- Latency:
  - Pin sclk edge to shift: SYNC_STAGES+1 clk.
  - Pin sel_n rise to addr update and done pulse: SYNC_STAGES+2 clk.
- Increment:
  - inc=1 in IDLE or SHIFT → addr <= addr+1 modulo 2^ADDR_W. 2^ADDR_W-1 wraps to 0; no flag.
  - inc in the COMMIT cycle is dropped; the committed value wins.
  - inc during SHIFT updates addr independently of shreg.
  - inc before the first commit still increments from 0; addr_valid stays 0.
- busy = (state != IDLE).
- sel_n rise with zero sclk edges: count=0, so frame_err=1.
- Reset mid-frame: partial frame lost; all outputs return to reset values.

Test Plan:
- Reset, then a 21-bit frame of 0x012345 → addr=0x012345 SYNC_STAGES+2 clk after sel_n rise; done high exactly 1 cycle; addr_valid=1; frame_err=0; busy low afterwards.
- After the above, 3 inc pulses → addr=0x012348; done stays 0.
- Frame 0x1FFFFF, then 1 inc → addr=0x000000; no other flag change.
- 20-bit frame, then a 22-bit frame, each after a good commit of 0x0000AA → frame_err=1 after each; addr stays 0x0000AA; no done pulse. Then a good frame 0x000055 → frame_err=0, addr=0x000055.
- inc asserted in the same cycle as COMMIT for frame 0x100000 → addr=0x100000, not 0x100001. Then inc held during the next frame's SHIFT → addr increments while the shift completes normally.
- reset pulled low after 10 of 21 bits → all outputs 0 and busy=0 immediately (async). After release, a full frame 0x0ABCDE → addr=0x0ABCDE.
